// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: one request at a time,
// fixed wait states, byte/half/word access and a single-cycle response pulse.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic               busy_q, busy_d;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               cur_we;
    logic [31:0]        cur_addr;
    logic [2:0]         cur_funct3;
    logic [31:0]        cur_wdata;
    logic               legal, misalign, out_of_range, fault;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        rd_word, load_data, wr_word, lane_data;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [3:0]         be;
    logic               commit, mem_we;

    // The zero-wait build commits on the accept edge, so it must see the live inputs.
    always_comb begin
        cur_we     = (state_q == S_IDLE) ? req_we     : we_q;
        cur_addr   = (state_q == S_IDLE) ? req_addr   : addr_q;
        cur_funct3 = (state_q == S_IDLE) ? req_funct3 : funct3_q;
        cur_wdata  = (state_q == S_IDLE) ? req_wdata  : wdata_q;
    end

    always_comb begin
        case (cur_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !cur_we;
            default:                legal = 1'b0;
        endcase
        misalign     = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                       ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
        out_of_range = {2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS);
        fault        = !legal || misalign || out_of_range;
        word_idx     = cur_addr[IDX_W+1:2];
        rd_word      = mem[word_idx];
    end

    // Load extraction and little-endian store lane merge.
    always_comb begin
        byte_sel = 8'(rd_word >> {cur_addr[1:0], 3'b000});
        half_sel = 16'(rd_word >> {cur_addr[1], 4'b0000});
        case (cur_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'b0, byte_sel};
            3'b101:  load_data = {16'b0, half_sel};
            default: load_data = '0;
        endcase
        case (cur_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be        = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                lane_data = cur_wdata;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            wr_word[b*8 +: 8] = be[b] ? lane_data[b*8 +: 8] : rd_word[b*8 +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d     = req_we;
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    wdata_d  = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        commit = (state_d == S_RESP) && (state_q != S_RESP);
        mem_we = commit && cur_we && !fault;
        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = fault;
            rsp_rdata_d = (fault || cur_we) ? 32'h0 : load_data;
        end
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Backing store is never reset; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) mem[word_idx] <= wr_word;
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
endmodule
